alu_issue_ctrl: RTL

Execute-stage issue controller that sits directly upstream of the ALU. It accepts one decoded operation at a time from decode over a valid/ready handshake and forwards a result that is still retiring as an operand. It holds the ALU inputs stable for the op-dependent latency (ADD/SUB short, MUL multi-cycle), then captures the result and zero flag and presents them to writeback over a second valid/ready handshake.

---
 rtl/alu_issue_ctrl_pkg.sv | 22 ++
 rtl/alu_operand_forward.sv | 17 +
 rtl/alu_issue_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared opcodes, default latencies and FSM encoding for the ALU issue controller.
package alu_issue_ctrl_pkg;

   localparam logic [1:0] ALU_OP_ADD  = 2'b00;
   localparam logic [1:0] ALU_OP_SUB  = 2'b01;
   localparam logic [1:0] ALU_OP_MUL  = 2'b10;
   localparam logic [1:0] ALU_OP_RSVD = 2'b11;

   localparam int ADD_LATENCY_DEF = 1;
   localparam int MUL_LATENCY_DEF = 5;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_EXEC     = 2'b01,
      ST_WAIT_OUT = 2'b10
   } state_t;

   function automatic logic op_is_exec(input logic [1:0] op);
      return op != ALU_OP_RSVD;
   endfunction

endpackage

// File: rtl/alu_operand_forward.sv
// Operand bypass mux: picks the retiring result when it targets this operand's register.
module alu_operand_forward #(
   parameter int DATA_WIDTH   = 32,
   parameter int REG_ID_WIDTH = 5
) (
   input  logic [REG_ID_WIDTH-1:0] op_id_i,
   input  logic [DATA_WIDTH-1:0]   op_val_i,
   input  logic [REG_ID_WIDTH-1:0] src_id_i,
   input  logic [DATA_WIDTH-1:0]   src_val_i,
   input  logic                    src_valid_i,
   output logic [DATA_WIDTH-1:0]   val_o
);

   // x0 is hardwired zero, so a write to it must never be bypassed.
   assign val_o = (src_valid_i && (src_id_i == op_id_i) && (op_id_i != '0)) ? src_val_i : op_val_i;

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage issue controller: accepts one op, holds ALU inputs for the op latency,
// captures the result and hands it to writeback.
//
// state       | meaning
// ST_IDLE     | no op in flight, ready for decode
// ST_EXEC     | ALU inputs held, counting down op latency
// ST_WAIT_OUT | result captured, waiting for writeback
module alu_issue_ctrl
   import alu_issue_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int REG_ID_WIDTH = 5,
   parameter int ADD_LATENCY  = ADD_LATENCY_DEF,
   parameter int MUL_LATENCY  = MUL_LATENCY_DEF,
   parameter int CNT_WIDTH    = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [1:0]              in_op,
   input  logic [DATA_WIDTH-1:0]   in_rs1_val,
   input  logic [DATA_WIDTH-1:0]   in_rs2_val,
   input  logic [REG_ID_WIDTH-1:0] in_rs1_id,
   input  logic [REG_ID_WIDTH-1:0] in_rs2_id,
   input  logic [REG_ID_WIDTH-1:0] in_rd_id,
   output logic [DATA_WIDTH-1:0]   alu_first,
   output logic [DATA_WIDTH-1:0]   alu_second,
   output logic [1:0]              alu_op,
   input  logic [DATA_WIDTH-1:0]   alu_result,
   input  logic                    alu_zero,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_WIDTH-1:0]   out_result,
   output logic                    out_zero,
   output logic [REG_ID_WIDTH-1:0] out_rd_id,
   output logic                    busy
);

   localparam logic [CNT_WIDTH-1:0] ADD_CNT = CNT_WIDTH'(ADD_LATENCY - 1);
   localparam logic [CNT_WIDTH-1:0] MUL_CNT = CNT_WIDTH'(MUL_LATENCY - 1);

   state_t                  state_q;
   logic [CNT_WIDTH-1:0]    cnt_q;
   logic [DATA_WIDTH-1:0]   alu_first_q, alu_second_q, out_result_q, fwd_val_q;
   logic [1:0]              alu_op_q;
   logic [REG_ID_WIDTH-1:0] rd_q, out_rd_id_q, fwd_rd_q;
   logic                    out_valid_q, out_zero_q, fwd_valid_q;

   logic                    accept, out_hs;
   logic [DATA_WIDTH-1:0]   src_val, rs1_fwd, rs2_fwd;
   logic [REG_ID_WIDTH-1:0] src_rd;
   logic                    src_valid;

   assign in_ready = !flush && ((state_q == ST_IDLE) || ((state_q == ST_WAIT_OUT) && out_ready));
   assign accept   = in_valid && in_ready;
   assign out_hs   = out_valid_q && out_ready && !flush;

   // A result retiring this cycle is newer than the registered forward copy.
   assign src_val   = out_hs ? out_result_q : fwd_val_q;
   assign src_rd    = out_hs ? out_rd_id_q  : fwd_rd_q;
   assign src_valid = out_hs || fwd_valid_q;

   alu_operand_forward #(.DATA_WIDTH(DATA_WIDTH), .REG_ID_WIDTH(REG_ID_WIDTH)) u_fwd_rs1 (
      .op_id_i     (in_rs1_id),
      .op_val_i    (in_rs1_val),
      .src_id_i    (src_rd),
      .src_val_i   (src_val),
      .src_valid_i (src_valid),
      .val_o       (rs1_fwd)
   );

   alu_operand_forward #(.DATA_WIDTH(DATA_WIDTH), .REG_ID_WIDTH(REG_ID_WIDTH)) u_fwd_rs2 (
      .op_id_i     (in_rs2_id),
      .op_val_i    (in_rs2_val),
      .src_id_i    (src_rd),
      .src_val_i   (src_val),
      .src_valid_i (src_valid),
      .val_o       (rs2_fwd)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         alu_first_q  <= '0;
         alu_second_q <= '0;
         alu_op_q     <= '0;
         rd_q         <= '0;
         out_result_q <= '0;
         out_rd_id_q  <= '0;
         out_zero_q   <= 1'b0;
         out_valid_q  <= 1'b0;
         fwd_val_q    <= '0;
         fwd_rd_q     <= '0;
         fwd_valid_q  <= 1'b0;
      end else if (flush) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         fwd_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            ST_EXEC: begin
               if (cnt_q == '0) begin
                  out_result_q <= alu_result;
                  out_zero_q   <= alu_zero;
                  out_rd_id_q  <= rd_q;
                  out_valid_q  <= 1'b1;
                  state_q      <= ST_WAIT_OUT;
               end else begin
                  cnt_q <= cnt_q - CNT_WIDTH'(1);
               end
            end
            ST_WAIT_OUT: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  fwd_val_q   <= out_result_q;
                  fwd_rd_q    <= out_rd_id_q;
                  fwd_valid_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: ;
         endcase

         // Accept overrides the WAIT_OUT exit so back-to-back ops go straight to EXEC.
         if (accept) begin
            if (op_is_exec(in_op)) begin
               alu_first_q  <= rs1_fwd;
               alu_second_q <= rs2_fwd;
               alu_op_q     <= in_op;
               rd_q         <= in_rd_id;
               cnt_q        <= (in_op == ALU_OP_MUL) ? MUL_CNT : ADD_CNT;
               state_q      <= ST_EXEC;
            end else begin
               state_q <= ST_IDLE;
            end
         end
      end
   end

   assign alu_first  = alu_first_q;
   assign alu_second = alu_second_q;
   assign alu_op     = alu_op_q;
   assign out_valid  = out_valid_q;
   assign out_result = out_result_q;
   assign out_zero   = out_zero_q;
   assign out_rd_id  = out_rd_id_q;
   assign busy       = (state_q != ST_IDLE);

endmodule
